conv_scheduler: RTL and testbench

CONV_SCHEDULER -- requirements
Module: conv_scheduler

---
 rtl/conv_scheduler_if.sv | 36 +++
 rtl/conv_scheduler.sv | 146 ++++++++++++++
 tb/tb_conv_scheduler.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_scheduler_if.sv
// Job, engine and result-stream signals of the convolution window scheduler.
// Signal prefixes are from the scheduler's point of view; the scheduler uses the slave modport.
interface conv_scheduler_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DIM_WIDTH  = 6
);
    // valid/ready: a transfer happens on every rising edge where both are high;
    // once valid is raised, it and its payload hold steady until that transfer.
    logic                  i_job_valid;
    logic                  o_job_ready;
    logic [DIM_WIDTH-1:0]  i_img_w;
    logic [DIM_WIDTH-1:0]  i_img_h;

    logic                  o_eng_start;
    logic [DIM_WIDTH-1:0]  o_eng_row;
    logic [DIM_WIDTH-1:0]  o_eng_col;
    logic                  i_eng_done;
    logic [DATA_WIDTH-1:0] i_eng_result;

    logic                  o_res_valid;
    logic                  i_res_ready;
    logic [DATA_WIDTH-1:0] o_res_data;
    logic                  o_res_last;

    modport slave (
        input  i_job_valid, i_img_w, i_img_h, i_eng_done, i_eng_result, i_res_ready,
        output o_job_ready, o_eng_start, o_eng_row, o_eng_col,
               o_res_valid, o_res_data, o_res_last
    );

    modport master (
        output i_job_valid, i_img_w, i_img_h, i_eng_done, i_eng_result, i_res_ready,
        input  o_job_ready, o_eng_start, o_eng_row, o_eng_col,
               o_res_valid, o_res_data, o_res_last
    );
endinterface

// File: rtl/conv_scheduler.sv
// Walks a KERNEL_SIZE window over a W x H image in raster order, issuing one engine
// operation at a time and buffering results in a small FIFO toward the result stream.
module conv_scheduler #(
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int DIM_WIDTH   = 6,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    conv_scheduler_if.slave bus,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err,
    output logic [1:0]      o_dbg_state
);
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = DATA_WIDTH + 1;
    localparam logic [DIM_WIDTH-1:0] K_DIM    = DIM_WIDTH'(KERNEL_SIZE);
    localparam logic [CNT_W-1:0]     FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t               state;
    logic [DIM_WIDTH-1:0] img_w;
    logic [DIM_WIDTH-1:0] img_h;
    logic [DIM_WIDTH-1:0] row;
    logic [DIM_WIDTH-1:0] col;

    logic [ENTRY_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;

    logic               fifo_full;
    logic               fifo_empty;
    logic               job_accept;
    logic               job_ok;
    logic               at_final_col;
    logic               at_final;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;

    always_comb begin
        fifo_full    = (count == FULL_CNT);
        fifo_empty   = (count == '0);
        job_accept   = bus.i_job_valid && (state == S_IDLE);
        job_ok       = (bus.i_img_w >= K_DIM) && (bus.i_img_h >= K_DIM);
        at_final_col = (col == (img_w - K_DIM));
        at_final     = at_final_col && (row == (img_h - K_DIM));
        push         = (state == S_WAIT) && bus.i_eng_done;
        pop          = !fifo_empty && bus.i_res_ready;
        head         = fifo_mem[rd_ptr];
    end

    // row/col only move on the done edge, so they stay put for the whole operation.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= S_IDLE;
            img_w  <= '0;
            img_h  <= '0;
            row    <= '0;
            col    <= '0;
            o_done <= 1'b0;
            o_err  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (job_accept) begin
                        img_w <= bus.i_img_w;
                        img_h <= bus.i_img_h;
                        row   <= '0;
                        col   <= '0;
                        if (job_ok) state <= S_ISSUE;
                        else        o_err <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (!fifo_full) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.i_eng_done) begin
                        if (at_final) begin
                            state <= S_DRAIN;
                        end else begin
                            state <= S_ISSUE;
                            if (at_final_col) begin
                                col <= '0;
                                row <= row + DIM_WIDTH'(1);
                            end else begin
                                col <= col + DIM_WIDTH'(1);
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty) begin
                        state  <= S_IDLE;
                        o_done <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A start is only issued with a free slot, so a push never finds the FIFO full.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) fifo_mem[wr_ptr] <= {bus.i_eng_result, at_final};
    end

    assign bus.o_job_ready = (state == S_IDLE);
    assign bus.o_eng_start = (state == S_ISSUE) && !fifo_full;
    assign bus.o_eng_row   = row;
    assign bus.o_eng_col   = col;
    assign bus.o_res_valid = !fifo_empty;
    assign bus.o_res_data  = fifo_empty ? '0 : head[ENTRY_W-1:1];
    assign bus.o_res_last  = !fifo_empty && head[0];
    assign o_busy          = (state != S_IDLE);
    assign o_dbg_state     = state;
endmodule

// File: tb/tb_conv_scheduler.sv
// Directed bench for conv_scheduler: engine model, ready driver, result scoreboard
// and a main flow of job scenarios ending in a single summary line.
module tb_conv_scheduler;
    localparam int K   = 3;
    localparam int DW  = 8;
    localparam int DIM = 6;
    localparam int RW  = DW + 1;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic       i_clk;
    logic       i_rst_n;
    logic       o_busy;
    logic       o_done;
    logic       o_err;
    logic [1:0] o_dbg_state;

    conv_scheduler_if #(.DATA_WIDTH(DW), .DIM_WIDTH(DIM)) bus ();

    conv_scheduler #(
        .KERNEL_SIZE(K), .DATA_WIDTH(DW), .DIM_WIDTH(DIM), .FIFO_DEPTH(4)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .bus         (bus),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_dbg_state (o_dbg_state)
    );

    int checks = 0;
    int errors = 0;

    logic [RW-1:0]    exp_q[$];
    logic [2*DIM-1:0] exp_start_q[$];

    int start_cnt = 0;
    int pop_cnt   = 0;
    int done_cnt  = 0;
    int simul_cnt = 0;
    int tag       = 0;
    int eng_delay = 2;
    int ready_mode = 1;
    int spur_req_cnt = 0;
    int spur_ack_cnt = 0;
    logic [2*DIM-1:0] last_start_pos = '0;

    // ---------------- clock ----------------
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, want the run to finish earlier");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge i_clk);
    endtask

    function automatic logic [DW-1:0] res_of(input int r, input int c, input int t);
        return DW'(t * 37 + r * 16 + c);
    endfunction

    // ---------------- engine model ----------------
    int               pend_cnt = 0;
    logic [DW-1:0]    pend_res = '0;
    logic [2*DIM-1:0] pend_pos = '0;

    initial begin : engine_model
        logic [2*DIM-1:0] exp_pos;
        bus.i_eng_done   = 1'b0;
        bus.i_eng_result = '0;
        forever begin
            @(posedge i_clk);
            #1;
            bus.i_eng_done = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt = pend_cnt - 1;
                if (pend_cnt == 0) begin
                    bus.i_eng_done   = 1'b1;
                    bus.i_eng_result = pend_res;
                    if (o_dbg_state == ST_WAIT)
                        check("eng_pos_stable", 32'({bus.o_eng_row, bus.o_eng_col}), 32'(pend_pos));
                end
            end else if (spur_req_cnt != spur_ack_cnt) begin
                spur_ack_cnt     = spur_req_cnt;
                bus.i_eng_done   = 1'b1;
                bus.i_eng_result = DW'(8'hEE);
            end
            if (bus.o_eng_start) begin
                start_cnt++;
                last_start_pos = {bus.o_eng_row, bus.o_eng_col};
                if (exp_start_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL start_unexpected: got start at row %0d col %0d, want none",
                             bus.o_eng_row, bus.o_eng_col);
                end else begin
                    exp_pos = exp_start_q.pop_front();
                    check("start_pos", 32'(last_start_pos), 32'(exp_pos));
                end
                pend_cnt = eng_delay;
                pend_pos = last_start_pos;
                pend_res = res_of(int'(bus.o_eng_row), int'(bus.o_eng_col), tag);
            end
        end
    end

    // ---------------- result ready driver ----------------
    initial begin : ready_driver
        bus.i_res_ready = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            case (ready_mode)
                0:       bus.i_res_ready = 1'b0;
                1:       bus.i_res_ready = 1'b1;
                default: bus.i_res_ready = ~bus.i_res_ready;
            endcase
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        logic [RW-1:0] exp_item;
        forever begin
            @(negedge i_clk);
            if (o_done) done_cnt++;
            if (bus.o_res_valid && bus.i_res_ready) begin
                pop_cnt++;
                if (bus.i_eng_done && o_dbg_state == ST_WAIT) simul_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL res_unexpected: got data %0h last %0b, want no result",
                             bus.o_res_data, bus.o_res_last);
                end else begin
                    exp_item = exp_q.pop_front();
                    check("res_data", 32'(bus.o_res_data), 32'(exp_item[RW-1:1]));
                    check("res_last", 32'(bus.o_res_last), 32'(exp_item[0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic submit(input int w, input int h);
        bit ok;
        int guard;
        ok = (w >= K) && (h >= K);
        guard = 0;
        tag++;
        if (ok) begin
            for (int r = 0; r <= h - K; r++) begin
                for (int c = 0; c <= w - K; c++) begin
                    exp_start_q.push_back({DIM'(r), DIM'(c)});
                    exp_q.push_back({res_of(r, c, tag), 1'(r == h - K && c == w - K)});
                end
            end
        end
        bus.i_img_w     = DIM'(w);
        bus.i_img_h     = DIM'(h);
        bus.i_job_valid = 1'b1;
        while (!bus.o_job_ready && guard < 500) begin
            tick();
            guard++;
        end
        check("job_ready_seen", 32'(bus.o_job_ready), 32'd1);
        tick();
        bus.i_job_valid = 1'b0;
        if (ok) begin
            check("first_start_latency", 32'(bus.o_eng_start), 32'd1);
            check("busy_after_accept", 32'(o_busy), 32'd1);
        end else begin
            check("err_pulse", 32'(o_err), 32'd1);
            check("busy_on_reject", 32'(o_busy), 32'd0);
            check("no_start_on_reject", 32'(bus.o_eng_start), 32'd0);
            tick();
            check("err_one_cycle", 32'(o_err), 32'd0);
            check("idle_after_reject", 32'(o_dbg_state), 32'(ST_IDLE));
        end
    endtask

    task automatic wait_done();
        int prev;
        int guard;
        prev = done_cnt;
        guard = 0;
        while (done_cnt == prev && guard < 1000) begin
            tick();
            guard++;
        end
        tick(2);
        check("done_once", 32'(done_cnt - prev), 32'd1);
        check("exp_results_drained", 32'(exp_q.size()), 32'd0);
        check("exp_starts_drained", 32'(exp_start_q.size()), 32'd0);
        check("idle_after_job", 32'(o_dbg_state), 32'(ST_IDLE));
    endtask

    // ---------------- main flow ----------------
    initial begin : main_flow
        int s_start;
        int s_pop;
        int s_sim;
        int s_done;
        int guard;

        i_rst_n         = 1'b0;
        bus.i_job_valid = 1'b0;
        bus.i_img_w     = '0;
        bus.i_img_h     = '0;
        tick(3);
        check("reset_busy", 32'(o_busy), 32'd0);
        check("reset_res_valid", 32'(bus.o_res_valid), 32'd0);
        check("reset_res_data", 32'(bus.o_res_data), 32'd0);
        check("reset_res_last", 32'(bus.o_res_last), 32'd0);
        check("reset_start", 32'(bus.o_eng_start), 32'd0);
        check("reset_done", 32'(o_done), 32'd0);
        check("reset_err", 32'(o_err), 32'd0);
        i_rst_n = 1'b1;
        tick();
        check("job_ready_after_reset", 32'(bus.o_job_ready), 32'd1);
        check("state_after_reset", 32'(o_dbg_state), 32'(ST_IDLE));

        // 4x4 image: four windows, results streamed straight out
        ready_mode = 1;
        s_start = start_cnt;
        s_pop   = pop_cnt;
        submit(4, 4);
        wait_done();
        check("starts_4x4", 32'(start_cnt - s_start), 32'd4);
        check("final_pos_4x4", 32'(last_start_pos), 32'({6'd1, 6'd1}));
        check("pops_4x4", 32'(pop_cnt - s_pop), 32'd4);

        // 7x3 image with the consumer stalled: FIFO fills after four results
        ready_mode = 0;
        tick(2);
        s_start = start_cnt;
        s_pop   = pop_cnt;
        submit(7, 3);
        tick(30);
        check("full_starts", 32'(start_cnt - s_start), 32'd4);
        check("full_state_issue", 32'(o_dbg_state), 32'(ST_ISSUE));
        check("full_no_start", 32'(bus.o_eng_start), 32'd0);
        check("full_res_valid", 32'(bus.o_res_valid), 32'd1);
        spur_req_cnt++;
        tick(4);
        check("spur_issue_state", 32'(o_dbg_state), 32'(ST_ISSUE));
        check("spur_issue_starts", 32'(start_cnt - s_start), 32'd4);
        ready_mode = 1;
        tick();
        ready_mode = 0;
        tick(10);
        check("one_pop", 32'(pop_cnt - s_pop), 32'd1);
        check("fifth_start", 32'(start_cnt - s_start), 32'd5);
        check("fifth_pos", 32'(last_start_pos), 32'({6'd0, 6'd4}));
        check("drain_state", 32'(o_dbg_state), 32'(ST_DRAIN));
        ready_mode = 1;
        wait_done();
        check("pops_7x3", 32'(pop_cnt - s_pop), 32'd5);

        // undersized image is rejected, then a normal job still runs
        s_start = start_cnt;
        s_done  = done_cnt;
        submit(2, 5);
        tick(3);
        check("reject_no_starts", 32'(start_cnt - s_start), 32'd0);
        check("reject_no_done", 32'(done_cnt - s_done), 32'd0);
        submit(5, 3);
        wait_done();
        check("starts_5x3", 32'(start_cnt - s_start), 32'd3);
        check("final_pos_5x3", 32'(last_start_pos), 32'({6'd0, 6'd2}));

        // stray engine completion while idle
        spur_req_cnt++;
        tick(3);
        check("spur_idle_state", 32'(o_dbg_state), 32'(ST_IDLE));
        check("spur_idle_res_valid", 32'(bus.o_res_valid), 32'd0);
        check("spur_idle_busy", 32'(o_busy), 32'd0);

        // reset while the engine is working on a 5x5 job
        eng_delay = 6;
        s_start = start_cnt;
        s_pop   = pop_cnt;
        submit(5, 5);
        tick();
        check("wait_before_reset", 32'(o_dbg_state), 32'(ST_WAIT));
        i_rst_n = 1'b0;
        #1;
        check("rst_state", 32'(o_dbg_state), 32'(ST_IDLE));
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_start", 32'(bus.o_eng_start), 32'd0);
        check("rst_res_valid", 32'(bus.o_res_valid), 32'd0);
        check("rst_res_data", 32'(bus.o_res_data), 32'd0);
        check("rst_res_last", 32'(bus.o_res_last), 32'd0);
        exp_q.delete();
        exp_start_q.delete();
        tick(2);
        i_rst_n = 1'b1;
        tick(8);
        check("late_done_state", 32'(o_dbg_state), 32'(ST_IDLE));
        check("late_done_res_valid", 32'(bus.o_res_valid), 32'd0);
        check("late_done_starts", 32'(start_cnt - s_start), 32'd1);
        check("late_done_pops", 32'(pop_cnt - s_pop), 32'd0);
        eng_delay = 2;
        s_start = start_cnt;
        submit(3, 3);
        wait_done();
        check("starts_3x3", 32'(start_cnt - s_start), 32'd1);
        check("pops_after_reset", 32'(pop_cnt - s_pop), 32'd1);

        // 6x4 image with ready toggling once a backlog has built up
        ready_mode = 0;
        tick(2);
        s_start = start_cnt;
        s_pop   = pop_cnt;
        s_sim   = simul_cnt;
        submit(6, 4);
        guard = 0;
        while (start_cnt - s_start < 4 && guard < 200) begin
            tick();
            guard++;
        end
        check("backlog_starts", 32'(start_cnt - s_start), 32'd4);
        ready_mode = 2;
        wait_done();
        check("starts_6x4", 32'(start_cnt - s_start), 32'd8);
        check("pops_6x4", 32'(pop_cnt - s_pop), 32'd8);
        check("final_pos_6x4", 32'(last_start_pos), 32'({6'd1, 6'd3}));
        check("simul_push_pop_seen", 32'(simul_cnt - s_sim > 0), 32'd1);

        ready_mode = 1;
        tick(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
